mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter_arb_prio.sv | 15 +
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbState_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int MAX_WAIT_DEFAULT = 4;
  localparam int STARVE_W         = 4;
  localparam logic [3:0] BE_FULL  = 4'hF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, bus and status signals of the memory arbiter; slave is the arbiter side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [ADDR_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [ADDR_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [ADDR_W-1:0] d_rdata;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W-1:0] m_wdata;
  logic [3:0]        m_be;
  logic              m_ready;
  logic              m_rvalid;
  logic [ADDR_W-1:0] m_rdata;

  logic              stall;
  logic              err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           m_ready, m_rvalid, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_be, stall, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           m_ready, m_rvalid, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_be, stall, err
  );

endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// Winner select: data side has priority unless fetch has been starved long enough.
module arb_prio (
  input  logic ifReq,
  input  logic dReq,
  input  logic starveHit,
  output logic grantIf,
  output logic grantD
);

  always_comb begin
    grantIf = ifReq && (!dReq || starveHit);
    grantD  = dReq && !grantIf;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between instruction fetch and data ports onto one memory bus.
//   state | meaning
//   IDLE  | no transaction; grant a pending requester and capture its request
//   ISSUE | m_req held with captured request until m_ready
//   WAIT  | waiting for m_rvalid, routed to the owner
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int ADDR_W   = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arbState_t           state;
  arbState_t           stateNext;
  owner_t              owner;
  logic [STARVE_W-1:0] starveCnt;
  logic [ADDR_W-1:0]   issueAddr;
  logic [ADDR_W-1:0]   issueWdata;
  logic                issueWe;
  logic [3:0]          issueBe;
  logic                errFlag;

  logic anyReq;
  logic starveHit;
  logic grantIf;
  logic grantD;

  assign anyReq    = bus.if_req | bus.d_req;
  assign starveHit = (starveCnt == STARVE_W'(MAX_WAIT));

  arb_prio u_arbPrio (
    .ifReq     (bus.if_req),
    .dReq      (bus.d_req),
    .starveHit (starveHit),
    .grantIf   (grantIf),
    .grantD    (grantD)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyReq)       stateNext = ISSUE;
      ISSUE:   if (bus.m_ready)  stateNext = WAIT;
      WAIT:    if (bus.m_rvalid) stateNext = IDLE;
      default:                   stateNext = IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is held, even though IDLE would otherwise grant.
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rdata   = '0;
    bus.m_req     = 1'b0;
    bus.m_we      = 1'b0;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.m_be      = 4'h0;
    bus.stall     = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          bus.if_gnt = grantIf;
          bus.d_gnt  = grantD;
          bus.stall  = anyReq;
        end
        ISSUE: begin
          bus.m_req   = 1'b1;
          bus.m_we    = issueWe;
          bus.m_addr  = issueAddr;
          bus.m_wdata = issueWdata;
          bus.m_be    = issueBe;
          bus.stall   = 1'b1;
        end
        WAIT: begin
          bus.stall = !bus.m_rvalid;
          if (bus.m_rvalid) begin
            if (owner == OWN_IF) begin
              bus.if_rvalid = 1'b1;
              bus.if_rdata  = bus.m_rdata;
            end else begin
              bus.d_rvalid = 1'b1;
              bus.d_rdata  = bus.m_rdata;
            end
          end
        end
        default: bus.stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_IF;
      starveCnt  <= '0;
      issueAddr  <= '0;
      issueWdata <= '0;
      issueWe    <= 1'b0;
      issueBe    <= 4'h0;
      errFlag    <= 1'b0;
    end else begin
      if (state == IDLE && anyReq) begin
        if (grantD) begin
          owner      <= OWN_D;
          issueAddr  <= bus.d_addr;
          issueWdata <= bus.d_wdata;
          issueWe    <= bus.d_we;
          issueBe    <= bus.d_be;
          if (bus.if_req && !starveHit) begin
            starveCnt <= starveCnt + STARVE_W'(1);
          end
        end else begin
          owner      <= OWN_IF;
          issueAddr  <= bus.if_addr;
          issueWdata <= '0;
          issueWe    <= 1'b0;
          issueBe    <= BE_FULL;
          starveCnt  <= '0;
        end
      end
      // A response that arrives while not waiting for one is a bus protocol error.
      if (bus.m_rvalid && state != WAIT) begin
        errFlag <= 1'b1;
      end
    end
  end

  assign bus.err = errFlag;

endmodule
